// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
//
// Sequences one image frame through the pixel datapath. The frame buffer is
// walked in raster order, one byte-addressed pixel read per unstalled cycle,
// with hsync marking the first pixel of each row and vsync the first pixel of
// the frame. A shift register matching the datapath latency carries each read
// address forward so the writeback address lines up with the processed pixel
// leaving the datapath.
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   start    : begin a frame (acted on only while idle)
//   abort    : cancel the current frame, back to idle on the next cycle
//   stall    : freeze sequencing and the datapath for this cycle
//   width    : pixels per row, captured when a frame is accepted
//   height   : rows per frame, captured when a frame is accepted
//   rd_en    : pixel read strobe
//   rd_addr  : byte address of the pixel read
//   en       : datapath enable
//   hsync    : current read is the first pixel of a row
//   vsync    : current read is the first pixel of the frame
//   wr_en    : processed-pixel write strobe
//   wr_addr  : byte address for the writeback
//   busy     : frame in progress (reading or draining)
//   done     : one-cycle pulse when a frame completes
// ---------------------------------------------------------------------------
module frame_sequencer #(
  parameter int ADDR_WIDTH      = 20,
  parameter int DIM_WIDTH       = 12,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int PIPE_LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  stall,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [DIM_WIDTH-1:0]  height,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Drain counter only has to reach PIPE_LATENCY-1.
  localparam int CNT_WIDTH = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam logic [CNT_WIDTH-1:0]  DRAIN_LAST = CNT_WIDTH'(PIPE_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BYTES_PER_PIXEL);
  localparam logic [DIM_WIDTH-1:0]  DIM_ONE    = DIM_WIDTH'(1);

  state_t                 state;
  logic [DIM_WIDTH-1:0]   width_q;
  logic [DIM_WIDTH-1:0]   height_q;
  logic [DIM_WIDTH-1:0]   x;
  logic [DIM_WIDTH-1:0]   y;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [CNT_WIDTH-1:0]   drain_cnt;

  // Write pipeline: stage 0 takes the current read, the last stage feeds
  // the writeback port.
  logic                   pipe_valid [PIPE_LATENCY];
  logic [ADDR_WIDTH-1:0]  pipe_addr  [PIPE_LATENCY];

  logic last_col;
  logic last_row;

  assign last_col = (x == width_q - DIM_ONE);
  assign last_row = (y == height_q - DIM_ONE);

  // -------------------------------------------------------------------------
  // Read/datapath strobes follow the state and stall in the same cycle so a
  // stall takes effect without a cycle of slip.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    rd_en = 1'b0;
    en    = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    unique case (state)
      RUN: begin
        if (!stall) begin
          rd_en = 1'b1;
          en    = 1'b1;
          hsync = (x == '0);
          vsync = (x == '0) && (y == '0);
        end
      end
      DRAIN:   en = !stall;
      default: ;
    endcase
  end

  assign rd_addr = addr;
  assign wr_en   = pipe_valid[PIPE_LATENCY-1] & en;
  assign wr_addr = pipe_addr[PIPE_LATENCY-1];
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

  // -------------------------------------------------------------------------
  // Frame control: state, raster counters and drain counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (!reset_n) begin
      state     <= IDLE;
      width_q   <= '0;
      height_q  <= '0;
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      drain_cnt <= '0;
    end else if (abort) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if ((width != '0) && (height != '0)) begin
              width_q  <= width;
              height_q <= height;
              x        <= '0;
              y        <= '0;
              addr     <= '0;
              state    <= RUN;
            end else begin
              // Empty frame: report completion without touching memory.
              state <= DONE;
            end
          end
        end

        RUN: begin
          if (!stall) begin
            addr <= addr + ADDR_STEP;
            if (last_col) begin
              x <= '0;
              if (last_row) begin
                y         <= '0;
                drain_cnt <= '0;
                state     <= DRAIN;
              end else begin
                y <= y + DIM_ONE;
              end
            end else begin
              x <= x + DIM_ONE;
            end
          end
        end

        DRAIN: begin
          // Only enabled cycles move data out of the datapath.
          if (!stall) begin
            if (drain_cnt == DRAIN_LAST) begin
              drain_cnt <= '0;
              state     <= DONE;
            end else begin
              drain_cnt <= drain_cnt + CNT_WIDTH'(1);
            end
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Write pipeline. It shifts only on enabled cycles, exactly like the
  // datapath, so a read issued on enabled cycle k reaches the writeback port
  // on enabled cycle k+PIPE_LATENCY regardless of stalls.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this is a handful of flops rather than a RAM, so clearing the
      // address stages too keeps wr_addr at 0 out of reset.
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_addr[i]  <= '0;
      end
    end else if (abort) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
      end
    end else if (en) begin
      pipe_valid[0] <= rd_en;
      pipe_addr[0]  <= rd_addr;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Structural invariants.
  // -------------------------------------------------------------------------
  a_wr_in_busy : assert property (@(posedge clk) disable iff (!reset_n)
                                  wr_en |-> busy);
  a_sync_rd    : assert property (@(posedge clk) disable iff (!reset_n)
                                  (hsync || vsync) |-> rd_en);
  a_vs_hs      : assert property (@(posedge clk) disable iff (!reset_n)
                                  vsync |-> hsync);
  a_done_pulse : assert property (@(posedge clk) disable iff (!reset_n)
                                  done |=> !done);

endmodule

// File: tb/tb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_sequencer
//
// Two instances: dut 0 with PIPE_LATENCY=2, dut 1 with PIPE_LATENCY=1, both
// 3 bytes per pixel. Stimulus pushes hand-computed expected events (read,
// write, busy cycle, done pulse, each tagged with its absolute cycle) into
// per-instance queues; an independent monitor pops and compares whenever a
// strobe is seen. Cycle n of a test is the n-th cycle after start was driven.
// ---------------------------------------------------------------------------
module tb_frame_sequencer;

  localparam int AW = 20;
  localparam int DW = 12;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic          hs;
    logic          vs;
  } rd_exp_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
  } wr_exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start [2];
  logic          abort;
  logic          stall;
  logic [DW-1:0] width;
  logic [DW-1:0] height;

  logic          rd_en_w   [2];
  logic [AW-1:0] rd_addr_w [2];
  logic          en_w      [2];
  logic          hsync_w   [2];
  logic          vsync_w   [2];
  logic          wr_en_w   [2];
  logic [AW-1:0] wr_addr_w [2];
  logic          busy_w    [2];
  logic          done_w    [2];

  rd_exp_t rd_q   [2][$];
  wr_exp_t wr_q   [2][$];
  int      busy_q [2][$];
  int      done_q [2][$];

  int cyc     = 0;
  int n_check = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_sequencer #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .BYTES_PER_PIXEL(3),
                    .PIPE_LATENCY(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort),
    .stall(stall), .width(width), .height(height),
    .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]), .en(en_w[0]),
    .hsync(hsync_w[0]), .vsync(vsync_w[0]), .wr_en(wr_en_w[0]),
    .wr_addr(wr_addr_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  frame_sequencer #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .BYTES_PER_PIXEL(3),
                    .PIPE_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort),
    .stall(stall), .width(width), .height(height),
    .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]), .en(en_w[1]),
    .hsync(hsync_w[1]), .vsync(vsync_w[1]), .wr_en(wr_en_w[1]),
    .wr_addr(wr_addr_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  rd_exp_t m_rd;
  wr_exp_t m_wr;
  int      m_c;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en_w[d]) begin
        if (rd_q[d].size() == 0) begin
          check($sformatf("dut%0d unexpected rd_en", d), 32'(rd_en_w[d]), 0);
        end else begin
          m_rd = rd_q[d].pop_front();
          check($sformatf("dut%0d rd cycle", d), cyc, m_rd.cyc);
          check($sformatf("dut%0d rd_addr", d), 32'(rd_addr_w[d]), 32'(m_rd.addr));
          check($sformatf("dut%0d hsync", d), 32'(hsync_w[d]), 32'(m_rd.hs));
          check($sformatf("dut%0d vsync", d), 32'(vsync_w[d]), 32'(m_rd.vs));
          check($sformatf("dut%0d en with rd", d), 32'(en_w[d]), 1);
        end
      end else begin
        check($sformatf("dut%0d sync without rd", d),
              32'({hsync_w[d], vsync_w[d]}), 0);
      end

      if (wr_en_w[d]) begin
        if (wr_q[d].size() == 0) begin
          check($sformatf("dut%0d unexpected wr_en", d), 32'(wr_en_w[d]), 0);
        end else begin
          m_wr = wr_q[d].pop_front();
          check($sformatf("dut%0d wr cycle", d), cyc, m_wr.cyc);
          check($sformatf("dut%0d wr_addr", d), 32'(wr_addr_w[d]), 32'(m_wr.addr));
        end
      end

      if (busy_w[d]) begin
        if (busy_q[d].size() == 0) begin
          check($sformatf("dut%0d unexpected busy", d), 32'(busy_w[d]), 0);
        end else begin
          m_c = busy_q[d].pop_front();
          check($sformatf("dut%0d busy cycle", d), cyc, m_c);
        end
      end

      if (done_w[d]) begin
        if (done_q[d].size() == 0) begin
          check($sformatf("dut%0d unexpected done", d), 32'(done_w[d]), 0);
        end else begin
          m_c = done_q[d].pop_front();
          check($sformatf("dut%0d done cycle", d), cyc, m_c);
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic exp_rd(input int d, input int c, input int a,
                        input bit hs, input bit vs);
    rd_q[d].push_back(rd_exp_t'{cyc: c, addr: AW'(a), hs: hs, vs: vs});
  endtask

  task automatic exp_wr(input int d, input int c, input int a);
    wr_q[d].push_back(wr_exp_t'{cyc: c, addr: AW'(a)});
  endtask

  task automatic exp_busy(input int d, input int first, input int last);
    for (int c = first; c <= last; c++) busy_q[d].push_back(c);
  endtask

  // Wait until the given absolute cycle, then settle 1 time unit past the edge.
  task automatic wait_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int d, input int w, input int h, output int base);
    @(posedge clk);
    #1;
    start[d] = 1'b1;
    width    = DW'(w);
    height   = DW'(h);
    base     = cyc;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  function automatic int pending();
    int n = 0;
    for (int d = 0; d < 2; d++)
      n += rd_q[d].size() + wr_q[d].size() + busy_q[d].size() + done_q[d].size();
    return n;
  endfunction

  task automatic clear_queues(input int d);
    rd_q[d].delete();
    wr_q[d].delete();
    busy_q[d].delete();
    done_q[d].delete();
  endtask

  // Bounded wait for every expected event, then a few idle cycles so late
  // or extra strobes are caught by the monitor.
  task automatic settle(input string tag);
    int n = 0;
    while (pending() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, " events outstanding"}, 32'(pending()), 0);
  endtask

  // Hand-computed 4x2 frame on dut0 (L=2), no stall.
  task automatic push_4x2(input int b);
    for (int i = 0; i < 8; i++) begin
      exp_rd(0, b + 1 + i, 3 * i, (i % 4) == 0, i == 0);
      exp_wr(0, b + 3 + i, 3 * i);
    end
    exp_busy(0, b + 1, b + 10);
    done_q[0].push_back(b + 11);
  endtask

  // ---------------------------------------------------------------- stimulus
  int b;
  int rc [8] = '{1, 2, 4, 5, 6, 7, 8, 10};
  int wc [8] = '{4, 5, 6, 7, 8, 10, 11, 12};

  initial begin
    reset_n  = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    abort    = 1'b0;
    stall    = 1'b0;
    width    = '0;
    height   = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset rd_en", d), 32'(rd_en_w[d]), 0);
      check($sformatf("dut%0d reset wr_en", d), 32'(wr_en_w[d]), 0);
      check($sformatf("dut%0d reset busy", d), 32'(busy_w[d]), 0);
      check($sformatf("dut%0d reset done", d), 32'(done_w[d]), 0);
      check($sformatf("dut%0d reset wr_addr", d), 32'(wr_addr_w[d]), 0);
    end
    #11;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 4x2 frame, no stall; a start pulse mid-frame must be ignored.
    do_start(0, 4, 2, b);
    push_4x2(b);
    wait_cycle(b + 5);
    start[0] = 1'b1;
    width    = DW'(1);
    height   = DW'(1);
    wait_cycle(b + 6);
    start[0] = 1'b0;
    settle("4x2");

    // Same frame with stalls in cycles 3 and 9.
    do_start(0, 4, 2, b);
    for (int i = 0; i < 8; i++) begin
      exp_rd(0, b + rc[i], 3 * i, (i % 4) == 0, i == 0);
      exp_wr(0, b + wc[i], 3 * i);
    end
    exp_busy(0, b + 1, b + 12);
    done_q[0].push_back(b + 13);
    wait_cycle(b + 3); stall = 1'b1;
    wait_cycle(b + 4); stall = 1'b0;
    wait_cycle(b + 9); stall = 1'b1;
    wait_cycle(b + 10); stall = 1'b0;
    settle("4x2 stall");

    // Empty frames: immediate done, no reads, never busy.
    do_start(0, 0, 2, b);
    done_q[0].push_back(b + 1);
    settle("width0");
    do_start(0, 5, 0, b);
    done_q[0].push_back(b + 1);
    settle("height0");

    // Abort in the cycle after the third read.
    do_start(0, 4, 2, b);
    for (int i = 0; i < 4; i++) exp_rd(0, b + 1 + i, 3 * i, i == 0, i == 0);
    exp_wr(0, b + 3, 0);
    exp_wr(0, b + 4, 3);
    exp_busy(0, b + 1, b + 4);
    wait_cycle(b + 4); abort = 1'b1;
    wait_cycle(b + 5); abort = 1'b0;
    check("abort busy next cycle", 32'(busy_w[0]), 0);
    settle("abort");

    // Restart after abort begins from address 0 with vsync.
    do_start(0, 4, 2, b);
    push_4x2(b);
    settle("restart");

    // Asynchronous reset mid-frame.
    do_start(0, 4, 2, b);
    push_4x2(b);
    wait_cycle(b + 3);
    #2;
    check("pre-reset rd_addr", 32'(rd_addr_w[0]), 6);
    reset_n = 1'b0;
    #1;
    check("async rd_en", 32'(rd_en_w[0]), 0);
    check("async rd_addr", 32'(rd_addr_w[0]), 0);
    check("async en", 32'(en_w[0]), 0);
    check("async hsync", 32'(hsync_w[0]), 0);
    check("async wr_en", 32'(wr_en_w[0]), 0);
    check("async wr_addr", 32'(wr_addr_w[0]), 0);
    check("async busy", 32'(busy_w[0]), 0);
    check("async done", 32'(done_w[0]), 0);
    clear_queues(0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    settle("reset");
    check("post-reset busy", 32'(busy_w[0]), 0);

    // 1x3 frame on dut1 (L=1): every read is a row start.
    do_start(1, 1, 3, b);
    for (int i = 0; i < 3; i++) begin
      exp_rd(1, b + 1 + i, 3 * i, 1'b1, i == 0);
      exp_wr(1, b + 2 + i, 3 * i);
    end
    exp_busy(1, b + 1, b + 4);
    done_q[1].push_back(b + 5);
    settle("1x3");

    // 3x1 frame on dut1: a single row, sync only on the first pixel.
    do_start(1, 3, 1, b);
    for (int i = 0; i < 3; i++) begin
      exp_rd(1, b + 1 + i, 3 * i, i == 0, i == 0);
      exp_wr(1, b + 2 + i, 3 * i);
    end
    exp_busy(1, b + 1, b + 4);
    done_q[1].push_back(b + 5);
    settle("3x1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
